// File: rtl/cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_tag_ctrl
// Brief    : Set-associative cache tag/state controller (valid/dirty/tag plus
//            NRU or tree-PLRU replacement) with valid/ready request/response.
//            Optional statistics counters: define CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_tag_ctrl #(
    parameter int  NUM_SETS           = 32,
    parameter int  NUM_WAYS           = 8,
    parameter int  LINE_SIZE          = 64,
    parameter int  REPLACEMENT_POLICY = 0,
    localparam int BS_W               = $clog2(LINE_SIZE),
    localparam int IDX_W              = $clog2(NUM_SETS),
    localparam int TAG_W              = 32 - IDX_W - BS_W,
    localparam int WAY_W              = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [31:0]      req_addr_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_hit_o,
    output logic [WAY_W-1:0] resp_way_o,
    output logic             resp_evict_o,
    output logic             resp_writeback_o,
    output logic [TAG_W-1:0] resp_victim_tag_o,
    output logic             resp_error_o,
    output logic [31:0]      stat_hits_o,
    output logic [31:0]      stat_misses_o,
    output logic [31:0]      stat_evictions_o,
    output logic [31:0]      stat_writebacks_o
);

    localparam logic [1:0] c_op_read  = 2'd0;
    localparam logic [1:0] c_op_write = 2'd1;
    localparam logic [1:0] c_op_inval = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_UPDATE = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic             w_accept, w_lookup, w_update;
    logic [1:0]       req_op_q;
    logic [TAG_W-1:0] req_tag_q;
    logic [IDX_W-1:0] req_idx_q;
    logic             lk_hit_q;
    logic [WAY_W-1:0] lk_way_q;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_mem_q [NUM_SETS][NUM_WAYS];

    logic [NUM_WAYS-1:0] w_set_valid, w_set_dirty, w_match, w_oh;
    logic [NUM_WAYS-1:0] w_valid_n, w_dirty_n;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way, w_victim, w_repl_victim;
    logic                w_fill, w_touch, w_inv_clr;

    logic             rsp_hit_d, rsp_evict_d, rsp_wb_d, rsp_err_d;
    logic [WAY_W-1:0] rsp_way_d;
    logic [TAG_W-1:0] rsp_vtag_d;
    logic             resp_hit_q, resp_evict_q, resp_wb_q, resp_err_q;
    logic [WAY_W-1:0] resp_way_q;
    logic [TAG_W-1:0] resp_vtag_q;

    logic unused_byte_sel;
    assign unused_byte_sel = ^req_addr_i[BS_W-1:0];

    function automatic logic [WAY_W-1:0] lowest_set(input logic [NUM_WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = WAY_W'(w);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        w_accept     = 1'b0;
        w_lookup     = 1'b0;
        w_update     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_accept = 1'b1;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_lookup = 1'b1;
                state_d  = S_UPDATE;
            end
            S_UPDATE: begin
                w_update = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lookup: tag compare and victim selection on the registered set
    // ------------------------------------------------------------------
    assign w_set_valid = valid_q[req_idx_q];
    assign w_set_dirty = dirty_q[req_idx_q];

    always_comb begin
        w_match = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_match[w] = w_set_valid[w] && (tag_mem_q[req_idx_q][w] == req_tag_q);
        end
    end

    assign w_hit     = |w_match;
    assign w_hit_way = lowest_set(w_match);
    // Empty ways are always filled before the replacement policy is consulted
    assign w_victim  = (&w_set_valid) ? w_repl_victim : lowest_set(~w_set_valid);

    // ------------------------------------------------------------------
    // Update: next contents of the addressed set and response fields
    // ------------------------------------------------------------------
    assign w_oh = NUM_WAYS'(1) << lk_way_q;

    always_comb begin
        w_valid_n   = w_set_valid;
        w_dirty_n   = w_set_dirty;
        w_fill      = 1'b0;
        w_touch     = 1'b0;
        w_inv_clr   = 1'b0;
        rsp_hit_d   = 1'b0;
        rsp_way_d   = '0;
        rsp_evict_d = 1'b0;
        rsp_wb_d    = 1'b0;
        rsp_vtag_d  = '0;
        rsp_err_d   = 1'b0;
        case (req_op_q)
            c_op_read, c_op_write: begin
                w_touch   = 1'b1;
                rsp_hit_d = lk_hit_q;
                rsp_way_d = lk_way_q;
                if (lk_hit_q) begin
                    if (req_op_q == c_op_write) w_dirty_n = w_set_dirty | w_oh;
                end else begin
                    w_fill    = 1'b1;
                    w_valid_n = w_set_valid | w_oh;
                    w_dirty_n = (req_op_q == c_op_write) ? (w_set_dirty | w_oh)
                                                         : (w_set_dirty & ~w_oh);
                    if (w_set_valid[lk_way_q]) begin
                        rsp_evict_d = 1'b1;
                        rsp_wb_d    = w_set_dirty[lk_way_q];
                        rsp_vtag_d  = tag_mem_q[req_idx_q][lk_way_q];
                    end
                end
            end
            c_op_inval: begin
                if (lk_hit_q) begin
                    w_inv_clr  = 1'b1;
                    w_valid_n  = w_set_valid & ~w_oh;
                    w_dirty_n  = w_set_dirty & ~w_oh;
                    rsp_hit_d  = 1'b1;
                    rsp_way_d  = lk_way_q;
                    rsp_wb_d   = w_set_dirty[lk_way_q];
                    rsp_vtag_d = tag_mem_q[req_idx_q][lk_way_q];
                end
            end
            default: rsp_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_op_q     <= '0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            lk_hit_q     <= 1'b0;
            lk_way_q     <= '0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_evict_q <= 1'b0;
            resp_wb_q    <= 1'b0;
            resp_vtag_q  <= '0;
            resp_err_q   <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (w_accept) begin
                req_op_q  <= req_op_i;
                req_tag_q <= req_addr_i[31 -: TAG_W];
                req_idx_q <= req_addr_i[BS_W +: IDX_W];
            end
            if (w_lookup) begin
                lk_hit_q <= w_hit;
                lk_way_q <= w_hit ? w_hit_way : w_victim;
            end
            if (w_update) begin
                valid_q[req_idx_q] <= w_valid_n;
                dirty_q[req_idx_q] <= w_dirty_n;
                resp_hit_q         <= rsp_hit_d;
                resp_way_q         <= rsp_way_d;
                resp_evict_q       <= rsp_evict_d;
                resp_wb_q          <= rsp_wb_d;
                resp_vtag_q        <= rsp_vtag_d;
                resp_err_q         <= rsp_err_d;
            end
        end
    end

    // Tag storage carries no reset; entries are only trusted behind valid
    always_ff @(posedge clk) begin
        if (w_update && w_fill) tag_mem_q[req_idx_q][lk_way_q] <= req_tag_q;
    end

    assign resp_hit_o        = resp_hit_q;
    assign resp_way_o        = resp_way_q;
    assign resp_evict_o      = resp_evict_q;
    assign resp_writeback_o  = resp_wb_q;
    assign resp_victim_tag_o = resp_vtag_q;
    assign resp_error_o      = resp_err_q;

    // ------------------------------------------------------------------
    // Replacement state
    // ------------------------------------------------------------------
    if (REPLACEMENT_POLICY == 0) begin : g_nru
        logic [NUM_WAYS-1:0] mru_q [NUM_SETS];
        logic [NUM_WAYS-1:0] mru_set, mru_d;

        assign mru_set       = mru_q[req_idx_q];
        assign w_repl_victim = (&mru_set) ? '0 : lowest_set(~mru_set);

        // Once every valid way is marked recent, only the touched one stays marked
        always_comb begin
            mru_d = mru_set;
            if (w_touch) begin
                mru_d = mru_set | w_oh;
                if (&(mru_d | ~w_valid_n)) mru_d = w_oh;
            end
            if (w_inv_clr) mru_d = mru_d & ~w_oh;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < NUM_SETS; s++) mru_q[s] <= '0;
            end else if (w_update) begin
                mru_q[req_idx_q] <= mru_d;
            end
        end
    end else begin : g_plru
        localparam int LVL    = $clog2(NUM_WAYS);
        localparam int NODES  = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
        localparam int NODE_W = (NODES > 1) ? $clog2(NODES) : 1;

        logic [NODES-1:0] plru_q [NUM_SETS];
        logic [NODES-1:0] plru_set, plru_d;

        assign plru_set = plru_q[req_idx_q];

        // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right)
        always_comb begin : b_walk
            int   node;
            logic b;
            node          = 0;
            b             = 1'b0;
            w_repl_victim = '0;
            for (int l = 0; l < LVL; l++) begin
                b             = plru_set[NODE_W'(node)];
                w_repl_victim = (w_repl_victim << 1) | WAY_W'(b);
                node          = 2 * node + 1 + int'(b);
            end
        end

        always_comb begin : b_touch
            int   node;
            logic b;
            node   = 0;
            b      = 1'b0;
            plru_d = plru_set;
            if (w_touch) begin
                for (int l = 0; l < LVL; l++) begin
                    b                      = lk_way_q[LVL-1-l];
                    plru_d[NODE_W'(node)]  = ~b;
                    node                   = 2 * node + 1 + int'(b);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
            end else if (w_update) begin
                plru_q[req_idx_q] <= plru_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, misses_q, evictions_q, writebacks_q;
    logic        w_rw_op;

    assign w_rw_op = (req_op_q == c_op_read) || (req_op_q == c_op_write);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q       <= '0;
            misses_q     <= '0;
            evictions_q  <= '0;
            writebacks_q <= '0;
        end else if (w_update) begin
            if (w_rw_op && lk_hit_q && (hits_q != '1))    hits_q       <= hits_q + 32'd1;
            if (w_rw_op && !lk_hit_q && (misses_q != '1)) misses_q     <= misses_q + 32'd1;
            if (rsp_evict_d && (evictions_q != '1))       evictions_q  <= evictions_q + 32'd1;
            if (rsp_wb_d && (writebacks_q != '1))         writebacks_q <= writebacks_q + 32'd1;
        end
    end

    assign stat_hits_o       = hits_q;
    assign stat_misses_o     = misses_q;
    assign stat_evictions_o  = evictions_q;
    assign stat_writebacks_o = writebacks_q;
`else
    assign stat_hits_o       = '0;
    assign stat_misses_o     = '0;
    assign stat_evictions_o  = '0;
    assign stat_writebacks_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/cache_tag_ctrl.md
Name: cache_tag_ctrl

Overview:
- Parametrised set-associative cache tag/state controller with a valid/ready request/response handshake. Successor to the trace-driven cache model.
- Keeps valid, dirty, tag and replacement state per set and way. Resolves read, write and invalidate requests, then reports hit, way, eviction and writeback per request.
- Sits between the trace driver (or CPU request port) and the memory-traffic model.

Parameters:
- num_sets, 32, number of sets; power of 2, ≥2.
- num_ways, 8, associativity; power of 2, 1..16.
- line_size, 64, line size in bytes; power of 2, 32..128.
- replacement_policy, 0, 0 = 1-bit NRU (MRU bits), 1 = tree pseudo-LRU.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, controller can accept a request.
- req_op, input, 2, 0 = read, 1 = write, 2 = invalidate, 3 = reserved.
- req_addr, input, 32, byte address split as {tag, index, byte_select}.
- resp_valid, output, 1, response present.
- resp_ready, input, 1, consumer accepts the response.
- resp_hit, output, 1, tag matched a valid way.
- resp_way, output, $clog2(num_ways) (min 1), way hit, filled or invalidated.
- resp_evict, output, 1, a valid line was replaced.
- resp_writeback, output, 1, the replaced or invalidated line was dirty.
- resp_victim_tag, output, TAG_SIZE, tag of the evicted or invalidated line; 0 otherwise.
- resp_error, output, 1, req_op was 3.
- stat_hits / stat_misses / stat_evictions / stat_writebacks, output, 32 each, statistics counters.

Behaviour:
- Address split: BYTE_SELECT = $clog2(line_size); INDEX = $clog2(num_sets); TAG = 32 − INDEX − BYTE_SELECT.
- FSM states: IDLE → LOOKUP → UPDATE → RESP → IDLE.
- IDLE: req_ready = 1. A request is accepted when req_valid && req_ready, and is registered. req_ready = 0 in all other states.
- LOOKUP: read the set, compare tags on valid ways, pick the victim.
- UPDATE: write the arrays and register the response fields.
- RESP: resp_valid = 1, fields held stable until resp_ready; the FSM moves to IDLE on the same edge. Minimum latency is 3 cycles from acceptance to resp_valid.
- Hit way: the lowest-numbered matching valid way.
- Victim way:
  - the lowest invalid way if any exists;
  - otherwise NRU picks the lowest way with mru = 0;
  - otherwise PLRU follows the tree bits (0 = left, 1 = right).
  - num_ways = 1: victim is always way 0.
- Read hit: touch the way.
- Read miss: fill victim with valid = 1, dirty = 0, tag written; touch it.
- Write hit: set dirty = 1; touch.
- Write miss: write-allocate; fill with dirty = 1; touch.
- Eviction: a miss whose victim was valid sets resp_evict = 1. resp_writeback = victim dirty.
- Invalidate hit: clear valid, dirty and mru of the way. PLRU bits unchanged. Report resp_hit = 1, resp_way, resp_victim_tag, and resp_writeback = old dirty.
- Invalidate miss: no state change; all flags 0.
- Touch, NRU: set mru[way]. If all valid ways then have mru = 1, clear every other way's mru bit.
- Touch, PLRU: on the path to the accessed way, set each node to point away from it.
- op = 3: no state change. resp_error = 1; all other response flags 0.
- Reset (asynchronous, any state):
  - valid, dirty, mru and PLRU bits all 0; FSM to IDLE.
  - req_ready = 1, resp_valid = 0, all response fields 0, counters 0.
  - An in-flight request is dropped with no response.
- Counters:
  - Hits and misses count read and write requests only.
  - Evictions count resp_evict.
  - Writebacks count every resp_writeback, invalidates included.
  - All counters saturate at 0xFFFF_FFFF.
  - Update occurs in UPDATE.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: stat_* counters are implemented as described above.
- Undefined: no counter registers; stat_* outputs are tied to 0. All other behaviour is identical.

Test Plan:
Config for all scenarios: num_sets = 4, num_ways = 2, line_size = 64, NRU unless stated. Tag = addr[31:8], index = addr[7:6].
- Reset, then read 0x000 → miss, way 0, evict = 0. Read 0x000 again → hit = 1, way 0. stat_hits = 1, stat_misses = 1.
- Read 0x000, write 0x100 (miss, way 1, dirty), read 0x000 (hit), read 0x200 → miss, way 1, evict = 1, writeback = 1, victim_tag = 0x000001.
- replacement_policy = 1, num_ways = 4: read 0x000, 0x100, 0x200, 0x300, 0x000, then 0x400 → miss, way 2, evict = 1, writeback = 0, victim_tag = 0x000002.
- Write 0x040 (set 1), invalidate 0x040 → hit = 1, writeback = 1, victim_tag = 0. Read 0x040 → miss, way 0, evict = 0.
- Hold resp_ready = 0 for 3 cycles with a second req_valid pending → resp fields stable, req_ready = 0, second request accepted only after the response handshake. req_op = 3 → resp_error = 1, no state change.
- Assert rst_n = 0 during LOOKUP of a read → no resp_valid, counters 0. A subsequent read of the same address misses.
